channel_to_pixel: RTL and testbench

- Inverse of the row→channel lookup used by the scope display: given a channel number, returns the pixel-row band that channel occupies on screen.
- Recomputes the layout sequentially whenever channel_enable changes: popcount, then a multi-cycle restoring divider, then a per-channel fill walk. No combinational divider.
- Answers single-cycle-latency lookup queries from the trace/label renderers.
- Band rule matches the row→channel mapping exactly: band height = (VGA_VER_RES-OFFSET)/count; nth enabled channel owns rows OFFSET+n*height .. OFFSET+(n+1)*height-1.

---
 rtl/channel_to_pixel.sv | 188 ++++++++++++++++++
 tb/tb_channel_to_pixel.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_to_pixel.sv
// Channel -> pixel-row band lookup for the scope display.
// The band table is rebuilt sequentially (popcount, restoring divide, fill walk) whenever channel_enable changes.
module channel_to_pixel #(
    parameter int MAX_CHAN_COUNT = 10,
    parameter int OFFSET         = 0,
    localparam int VGA_VER_RES   = 480,
    localparam int ROW_W         = $clog2(VGA_VER_RES),
    localparam int CH_W          = $clog2(MAX_CHAN_COUNT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
    input  logic                      query_valid,
    input  logic [CH_W-1:0]           query_channel,
    output logic                      layout_valid,
    output logic [ROW_W-1:0]          channel_height,
    output logic                      resp_valid,
    output logic                      resp_enabled,
    output logic [ROW_W-1:0]          resp_top_row,
    output logic [ROW_W-1:0]          resp_bottom_row
);

    localparam int POP_W  = $clog2(MAX_CHAN_COUNT + 1);
    localparam int STEP_W = $clog2(ROW_W + MAX_CHAN_COUNT);
    localparam logic [ROW_W-1:0]  DIVIDEND  = ROW_W'(VGA_VER_RES - OFFSET);
    localparam logic [ROW_W-1:0]  ROW_BASE  = ROW_W'(OFFSET);
    localparam logic [STEP_W-1:0] DIV_LAST  = STEP_W'(ROW_W - 1);
    localparam logic [STEP_W-1:0] FILL_LAST = STEP_W'(MAX_CHAN_COUNT - 1);

    typedef enum logic [2:0] {IDLE, COUNT, DIVIDE, FILL, READY} state_t;

    state_t                    state_q, state_d;
    logic [MAX_CHAN_COUNT-1:0] en_q;
    logic                      first_q;
    logic                      change;
    logic [POP_W-1:0]          pop, count_q;
    logic [STEP_W-1:0]         step_q;
    logic [ROW_W-1:0]          rem_q, quo_q, acc_q, quo_next;
    logic [ROW_W:0]            trial, divisor, rem_full;
    logic                      take;
    logic                      div_start, div_step, div_exit, fill_step, fill_clear;
    logic [CH_W-1:0]           fill_idx, q_idx;
    logic                      q_in_range, q_hit;

    logic                      en_tab  [MAX_CHAN_COUNT];
    logic [ROW_W-1:0]          top_tab [MAX_CHAN_COUNT];
    logic [ROW_W-1:0]          bot_tab [MAX_CHAN_COUNT];

    // A forced change on the first edge after reset makes the layout track the input without waiting for a toggle.
    assign change = first_q || (channel_enable != en_q);

    // NOTE: clocked blocks use '<=' only; '=' in an always_ff makes simulation order-dependent and diverge from synthesis.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= '0;
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (change) en_q <= channel_enable;
        end
    end

    // NOTE: every always_comb assigns all its outputs a default first, so no path infers a latch.
    always_comb begin
        pop = '0;
        for (int i = 0; i < MAX_CHAN_COUNT; i++) pop = pop + POP_W'(en_q[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (change) begin
            state_d = COUNT;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                COUNT:   state_d = (pop == '0) ? READY : DIVIDE;
                DIVIDE:  if (step_q == DIV_LAST)  state_d = FILL;
                FILL:    if (step_q == FILL_LAST) state_d = READY;
                READY:   state_d = READY;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        div_start  = 1'b0;
        div_step   = 1'b0;
        div_exit   = 1'b0;
        fill_step  = 1'b0;
        fill_clear = 1'b0;
        if (!change) begin
            unique case (state_q)
                COUNT:   if (pop == '0) fill_clear = 1'b1; else div_start = 1'b1;
                DIVIDE:  begin div_step = 1'b1; div_exit = (step_q == DIV_LAST); end
                FILL:    fill_step = 1'b1;
                default: ;
            endcase
        end
    end

    // Restoring division: shift the next dividend bit into the remainder, subtract the count when it fits.
    assign divisor  = (ROW_W + 1)'(count_q);
    assign trial    = {rem_q, quo_q[ROW_W-1]};
    assign take     = (trial >= divisor);
    assign rem_full = take ? (trial - divisor) : trial;
    assign quo_next = {quo_q[ROW_W-2:0], take};
    assign fill_idx = step_q[CH_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q        <= '0;
            step_q         <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            acc_q          <= '0;
            channel_height <= '0;
        end else begin
            if (div_start) begin
                count_q <= pop;
                step_q  <= '0;
                rem_q   <= '0;
                quo_q   <= DIVIDEND;
            end
            if (div_step) begin
                rem_q  <= rem_full[ROW_W-1:0];
                quo_q  <= quo_next;
                step_q <= step_q + STEP_W'(1);
                if (div_exit) begin
                    channel_height <= quo_next;
                    acc_q          <= ROW_BASE;
                    step_q         <= '0;
                end
            end
            if (fill_clear) channel_height <= '0;
            if (fill_step) begin
                step_q <= step_q + STEP_W'(1);
                if (en_q[fill_idx]) acc_q <= acc_q + channel_height;
            end
        end
    end

    // NOTE: the table is small and must read as "all disabled" right after reset, so it is built from resettable flops rather than RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_CHAN_COUNT; i++) begin
                en_tab[i]  <= 1'b0;
                top_tab[i] <= '0;
                bot_tab[i] <= '0;
            end
        end else if (fill_clear) begin
            for (int i = 0; i < MAX_CHAN_COUNT; i++) begin
                en_tab[i]  <= 1'b0;
                top_tab[i] <= '0;
                bot_tab[i] <= '0;
            end
        end else if (fill_step) begin
            en_tab[fill_idx]  <= en_q[fill_idx];
            top_tab[fill_idx] <= en_q[fill_idx] ? acc_q : '0;
            bot_tab[fill_idx] <= en_q[fill_idx] ? (acc_q + channel_height - ROW_W'(1)) : '0;
        end
    end

    assign q_in_range = ({1'b0, query_channel} < (CH_W + 1)'(MAX_CHAN_COUNT));
    assign q_idx      = q_in_range ? query_channel : '0;
    assign q_hit      = query_valid && layout_valid && !change && q_in_range && en_tab[q_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layout_valid    <= 1'b0;
            resp_valid      <= 1'b0;
            resp_enabled    <= 1'b0;
            resp_top_row    <= '0;
            resp_bottom_row <= '0;
        end else begin
            layout_valid    <= !change && (state_q == READY);
            resp_valid      <= query_valid;
            resp_enabled    <= q_hit;
            resp_top_row    <= q_hit ? top_tab[q_idx] : '0;
            resp_bottom_row <= q_hit ? bot_tab[q_idx] : '0;
        end
    end

endmodule

// File: tb/tb_channel_to_pixel.sv
// Bench for channel_to_pixel: two instances (OFFSET 0 and 32) share stimulus; a reference model
// tracks layout timing and band rows, and a query scoreboard is compared on every response.
module tb_channel_to_pixel;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] channel_enable;
    logic       query_valid;
    logic [3:0] query_channel;

    logic       lv_a, rv_a, re_a, lv_b, rv_b, re_b;
    logic [8:0] h_a, rt_a, rb_a, h_b, rt_b, rb_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    channel_to_pixel #(.MAX_CHAN_COUNT(10), .OFFSET(0)) dut_a (
        .clk(clk), .reset(reset), .channel_enable(channel_enable),
        .query_valid(query_valid), .query_channel(query_channel),
        .layout_valid(lv_a), .channel_height(h_a), .resp_valid(rv_a),
        .resp_enabled(re_a), .resp_top_row(rt_a), .resp_bottom_row(rb_a)
    );

    channel_to_pixel #(.MAX_CHAN_COUNT(10), .OFFSET(32)) dut_b (
        .clk(clk), .reset(reset), .channel_enable(channel_enable),
        .query_valid(query_valid), .query_channel(query_channel),
        .layout_valid(lv_b), .channel_height(h_b), .resp_valid(rv_b),
        .resp_enabled(re_b), .resp_top_row(rt_b), .resp_bottom_row(rb_b)
    );

    typedef struct {
        logic       e_a;
        logic [8:0] t_a, b_a;
        logic       e_b;
        logic [8:0] t_b, b_b;
    } resp_t;

    resp_t sb_q[$];

    logic [9:0] m_en;
    bit         m_first, m_valid, exp_pulse;
    int         m_cnt, m_lat;

    function automatic int model_height(input int off, input logic [9:0] en);
        int c = 0;
        for (int i = 0; i < 10; i++) c += int'(en[i]);
        return (c == 0) ? 0 : (480 - off) / c;
    endfunction

    function automatic void model_entry(input int off, input logic [9:0] en, input int ch,
                                        output logic e, output logic [8:0] top, output logic [8:0] bot);
        int h, acc;
        e = 1'b0; top = '0; bot = '0;
        if (ch < 10) begin
            if (en[ch]) begin
                h   = model_height(off, en);
                acc = off;
                for (int k = 0; k < ch; k++) if (en[k]) acc += h;
                e   = 1'b1;
                top = 9'(acc);
                bot = 9'(acc + h - 1);
            end
        end
    endfunction

    // Reference model: layout timing from the enable history, expected responses pushed per query.
    always @(posedge clk or posedge reset) begin : model
        bit    chg;
        resp_t r;
        if (reset) begin
            m_first = 1'b1; m_valid = 1'b0; m_cnt = 0; m_lat = 0; m_en = '0;
            exp_pulse = 1'b0;
            sb_q.delete();
        end else begin
            chg = m_first || (channel_enable != m_en);
            exp_pulse = query_valid;
            if (query_valid) begin
                r.e_a = 1'b0; r.t_a = '0; r.b_a = '0;
                r.e_b = 1'b0; r.t_b = '0; r.b_b = '0;
                if (m_valid && !chg) begin
                    model_entry(0,  m_en, int'(query_channel), r.e_a, r.t_a, r.b_a);
                    model_entry(32, m_en, int'(query_channel), r.e_b, r.t_b, r.b_b);
                end
                sb_q.push_back(r);
            end
            if (chg) begin
                m_en = channel_enable; m_first = 1'b0; m_valid = 1'b0; m_cnt = 0;
                m_lat = ($countones(channel_enable) == 0) ? 2 : 21;
            end else if (!m_valid) begin
                m_cnt++;
                if (m_cnt == m_lat) m_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        resp_t r;
        if (!reset) begin
            checks++;
            if (lv_a !== m_valid || lv_b !== m_valid) begin
                errors++;
                $display("FAIL layout_valid @%0t: got a=%0b b=%0b expected %0b", $time, lv_a, lv_b, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (h_a !== 9'(model_height(0, m_en)) || h_b !== 9'(model_height(32, m_en))) begin
                    errors++;
                    $display("FAIL channel_height @%0t: got a=%0d b=%0d expected a=%0d b=%0d", $time,
                             h_a, h_b, model_height(0, m_en), model_height(32, m_en));
                end
            end
            checks++;
            if (rv_a !== exp_pulse || rv_b !== exp_pulse) begin
                errors++;
                $display("FAIL resp_valid @%0t: got a=%0b b=%0b expected %0b", $time, rv_a, rv_b, exp_pulse);
            end
            if (exp_pulse) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got response with no expected entry queued", $time);
                end else begin
                    r = sb_q.pop_front();
                    if (re_a !== r.e_a || rt_a !== r.t_a || rb_a !== r.b_a ||
                        re_b !== r.e_b || rt_b !== r.t_b || rb_b !== r.b_b) begin
                        errors++;
                        $display("FAIL resp_fields @%0t: got a=%0b:%0d..%0d b=%0b:%0d..%0d expected a=%0b:%0d..%0d b=%0b:%0d..%0d",
                                 $time, re_a, rt_a, rb_a, re_b, rt_b, rb_b, r.e_a, r.t_a, r.b_a, r.e_b, r.t_b, r.b_b);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic query(input int ch);
        query_valid   = 1'b1;
        query_channel = 4'(ch);
        tick();
        query_valid   = 1'b0;
    endtask

    // Called right after a new enable value is driven; the next edge latches it.
    task automatic check_latency(input int lat);
        for (int i = 0; i <= lat; i++) begin
            tick();
            if (i == lat - 1) begin
                checks++;
                if (lv_a !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early: layout_valid=%0b after %0d edges, expected 0", lv_a, i);
                end
            end
            if (i == lat) begin
                checks++;
                if (lv_a !== 1'b1 || lv_b !== 1'b1) begin
                    errors++;
                    $display("FAIL latency: layout_valid a=%0b b=%0b after %0d edges, expected 1", lv_a, lv_b, lat);
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({lv_a, rv_a, re_a, h_a, rt_a, rb_a, lv_b, rv_b, re_b, h_b, rt_b, rb_b} !== '0) begin
            errors++;
            $display("FAIL %s: outputs a=%0b%0b%0b h%0d %0d..%0d b=%0b%0b%0b h%0d %0d..%0d, expected all 0", name,
                     lv_a, rv_a, re_a, h_a, rt_a, rb_a, lv_b, rv_b, re_b, h_b, rt_b, rb_b);
        end
    endtask

    task automatic check_heights(input string name, input int ea, input int eb);
        checks++;
        if (h_a !== 9'(ea) || h_b !== 9'(eb)) begin
            errors++;
            $display("FAIL %s: height got a=%0d b=%0d expected a=%0d b=%0d", name, h_a, h_b, ea, eb);
        end
    endtask

    task automatic check_resp_a(input string name, input logic e, input int top, input int bot);
        checks++;
        if (rv_a !== 1'b1 || re_a !== e || rt_a !== 9'(top) || rb_a !== 9'(bot)) begin
            errors++;
            $display("FAIL %s: got v=%0b e=%0b %0d..%0d expected v=1 e=%0b %0d..%0d", name,
                     rv_a, re_a, rt_a, rb_a, e, top, bot);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_zero_enable();
        channel_enable = '0;
        check_latency(2);
        check_heights("zero_height", 0, 0);
        for (int ch = 0; ch < 10; ch++) query(ch);
        query(15);
        check_resp_a("zero_ch15", 1'b0, 0, 0);
    endtask

    task automatic test_three_channels();
        channel_enable = 10'b00_0010_0101;
        check_latency(21);
        check_heights("three_height", 160, 149);
        query(0); check_resp_a("three_ch0", 1'b1, 0, 159);
        query(1); check_resp_a("three_ch1", 1'b0, 0, 0);
        query(2); check_resp_a("three_ch2", 1'b1, 160, 319);
        query(3);
        query(5); check_resp_a("three_ch5", 1'b1, 320, 479);
    endtask

    task automatic test_all_and_seven();
        channel_enable = 10'h3FF;
        check_latency(21);
        check_heights("all_height", 48, 44);
        query(9); check_resp_a("all_ch9", 1'b1, 432, 479);
        channel_enable = 10'b00_0111_1111;
        check_latency(21);
        check_heights("seven_height", 68, 64);
        query(6); check_resp_a("seven_ch6", 1'b1, 408, 475);
        query(7); check_resp_a("seven_ch7", 1'b0, 0, 0);
    endtask

    task automatic test_change_mid_fill();
        channel_enable = 10'b10_1010_1010;
        repeat (15) tick();
        query(0); check_resp_a("recompute_query", 1'b0, 0, 0);
        channel_enable = 10'b00_0011_0011;
        check_latency(21);
        check_heights("restart_height", 120, 112);
        for (int ch = 0; ch < 10; ch++) query(ch);
        query(4); check_resp_a("restart_ch4", 1'b1, 240, 359);
    endtask

    task automatic test_change_with_query();
        channel_enable = 10'b00_0000_0001;
        query(4); check_resp_a("change_and_query", 1'b0, 0, 0);
        check_latency(20);
        check_heights("single_height", 480, 448);
        query(0); check_resp_a("single_ch0", 1'b1, 0, 479);
    endtask

    task automatic test_reset_mid_divide();
        channel_enable = 10'b00_0000_1111;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1 check_zero_outputs("reset_mid_divide");
        tick();
        reset = 1'b0;
        check_latency(21);
        check_heights("post_reset_height", 120, 112);
    endtask

    task automatic test_offset_back_to_back();
        channel_enable = 10'b00_0000_0011;
        check_latency(21);
        check_heights("offset_height", 240, 224);
        for (int i = 0; i < 12; i++) begin
            query(i % 2);
            checks++;
            if (rv_b !== 1'b1 || re_b !== 1'b1 ||
                rt_b !== ((i % 2 == 0) ? 9'd32 : 9'd256) || rb_b !== ((i % 2 == 0) ? 9'd255 : 9'd479)) begin
                errors++;
                $display("FAIL offset_b2b[%0d]: got v=%0b e=%0b %0d..%0d", i, rv_b, re_b, rt_b, rb_b);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        channel_enable = '0;
        query_valid    = 1'b0;
        query_channel  = '0;
        test_reset();
        test_zero_enable();
        test_three_channels();
        test_all_and_seven();
        test_change_mid_fill();
        test_change_with_query();
        test_reset_mid_divide();
        test_offset_back_to_back();
        repeat (3) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
